// File: rtl/loadstore_seq.sv
// rtl/loadstore_seq.sv - multi-cycle load/store sequencer between decode, register file and data memory
module loadstore_seq #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 22,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [4:0]        opcode,
  input  logic [REG_W-1:0]  rdst,
  input  logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [REG_W-1:0]  regsrc1,
  output logic              regread,
  input  logic [DATA_W-1:0] regout1,
  output logic [REG_W-1:0]  regdst,
  output logic [DATA_W-1:0] regin,
  output logic              regwrite,
  output logic [ADDR_W-1:0] memaddress,
  output logic [DATA_W-1:0] memin,
  output logic [DATA_W/8-1:0] membe,
  output logic              memread,
  output logic              memwrite,
  input  logic [DATA_W-1:0] memout,
  input  logic              memready
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDREG,
    S_MEMACC,
    S_WB,
    S_FIN
  } state_t;

  state_t             state;
  logic               is_store;
  logic               sext;
  logic [1:0]         size;
  logic [REG_W-1:0]   rd;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data;
  logic               errflag;
  logic [CNT_W-1:0]   cnt;

  // Store data trimmed to the access size; upper bits are forced to zero.
  function automatic logic [DATA_W-1:0] trim(input logic [DATA_W-1:0] d, input logic [1:0] sz);
    case (sz)
      2'b01:   trim = DATA_W'(d[15:0]);
      2'b10:   trim = DATA_W'(d[7:0]);
      default: trim = d;
    endcase
  endfunction

  // Load data taken from the low lanes, optionally sign-extended from the field's top bit.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d, input logic [1:0] sz,
                                               input logic sx);
    case (sz)
      2'b01:   extend = sx ? DATA_W'($signed(d[15:0])) : DATA_W'(d[15:0]);
      2'b10:   extend = sx ? DATA_W'($signed(d[7:0])) : DATA_W'(d[7:0]);
      default: extend = d;
    endcase
  endfunction

  // Byte-lane enables: word uses every lane, half the low two, byte lane 0.
  function automatic logic [BE_W-1:0] lanes(input logic [1:0] sz);
    case (sz)
      2'b01:   lanes = BE_W'(2'b11);
      2'b10:   lanes = BE_W'(1'b1);
      default: lanes = '1;
    endcase
  endfunction

  // Sequencer: next state and the registered strobes for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      is_store   <= 1'b0;
      sext       <= 1'b0;
      size       <= 2'b00;
      rd         <= '0;
      addr       <= '0;
      data       <= '0;
      errflag    <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      regsrc1    <= '0;
      regread    <= 1'b0;
      regdst     <= '0;
      regin      <= '0;
      regwrite   <= 1'b0;
      memaddress <= '0;
      memin      <= '0;
      membe      <= '0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      regsrc1    <= '0;
      regread    <= 1'b0;
      regdst     <= '0;
      regin      <= '0;
      regwrite   <= 1'b0;
      memaddress <= '0;
      memin      <= '0;
      membe      <= '0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && opcode[4]) begin
            is_store <= opcode[3];
            sext     <= opcode[2];
            size     <= opcode[1:0];
            rd       <= rdst;
            addr     <= address;
            cnt      <= '0;
            busy     <= 1'b1;
            if (opcode[1:0] == 2'b11) begin
              state   <= S_FIN;
              errflag <= 1'b1;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (opcode[3]) begin
              state   <= S_RDREG;
              regread <= 1'b1;
              regsrc1 <= rdst;
            end else begin
              state      <= S_MEMACC;
              memread    <= 1'b1;
              memaddress <= address;
              membe      <= lanes(opcode[1:0]);
            end
          end
        end
        S_RDREG: begin
          state      <= S_MEMACC;
          data       <= trim(regout1, size);
          memwrite   <= 1'b1;
          memaddress <= addr;
          memin      <= trim(regout1, size);
          membe      <= lanes(size);
        end
        S_MEMACC: begin
          if (memready) begin
            if (is_store) begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= errflag;
            end else begin
              state    <= S_WB;
              data     <= extend(memout, size, sext);
              regwrite <= 1'b1;
              regdst   <= rd;
              regin    <= extend(memout, size, sext);
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= S_FIN;
            errflag <= 1'b1;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            memread    <= ~is_store;
            memwrite   <= is_store;
            memaddress <= addr;
            memin      <= is_store ? data : '0;
            membe      <= lanes(size);
          end
        end
        S_WB: begin
          state <= S_FIN;
          done  <= 1'b1;
          err   <= errflag;
        end
        S_FIN: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          errflag <= 1'b0;
          cnt     <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loadstore_seq.sv
// tb/tb_loadstore_seq.sv - directed self-checking bench for loadstore_seq
module tb_loadstore_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  opcode = '0;
  logic [4:0]  rdst = '0;
  logic [21:0] address = '0;
  logic        busy, done, err;
  logic [4:0]  regsrc1, regdst;
  logic        regread, regwrite;
  logic [31:0] regout1 = '0;
  logic [31:0] regin;
  logic [21:0] memaddress;
  logic [31:0] memin;
  logic [3:0]  membe;
  logic        memread, memwrite;
  logic [31:0] memout = '0;
  logic        memready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [6:0] flags;
  logic       any_data;
  assign flags    = {busy, done, err, regread, regwrite, memread, memwrite};
  assign any_data = |{regsrc1, regdst, regin, memaddress, memin, membe};

  loadstore_seq #(.DATA_W(32), .ADDR_W(22), .REG_W(5), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .rdst(rdst), .address(address),
    .busy(busy), .done(done), .err(err),
    .regsrc1(regsrc1), .regread(regread), .regout1(regout1),
    .regdst(regdst), .regin(regin), .regwrite(regwrite),
    .memaddress(memaddress), .memin(memin), .membe(membe), .memread(memread), .memwrite(memwrite),
    .memout(memout), .memready(memready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and step past the sampling edge; caller is then in cycle 1.
  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [21:0] ad);
    opcode  = op;
    rdst    = rd;
    address = ad;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
  endtask

  logic [4:0]  lop [4] = '{5'b10001, 5'b10101, 5'b10010, 5'b10100};
  logic [31:0] lmem[4] = '{32'hCAFE8001, 32'hCAFE8001, 32'h12345680, 32'h80000000};
  logic [31:0] lexp[4] = '{32'h00008001, 32'hFFFF8001, 32'h00000080, 32'h80000000};

  int  mr_cycles;
  int  done_cnt;
  bit  saw_wr, saw_done, done_err;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("reset_flags", flags, 0);
    check("reset_data", any_data, 0);

    // store word
    regout1  = 32'hDEADBEEF;
    memready = 1'b1;
    issue(5'b11000, 5'd7, 22'h00ABC);
    check("sw_c1_regread", regread, 1);
    check("sw_c1_regsrc1", regsrc1, 7);
    check("sw_c1_busy", busy, 1);
    tick();
    check("sw_c2_memwrite", memwrite, 1);
    check("sw_c2_memaddress", memaddress, 22'h00ABC);
    check("sw_c2_memin", memin, 32'hDEADBEEF);
    check("sw_c2_membe", membe, 4'b1111);
    check("sw_c2_regread", regread, 0);
    tick();
    check("sw_c3_done_err", {done, err}, 2'b10);
    check("sw_c3_memwrite", memwrite, 0);
    tick();
    check("sw_c4_busy", busy, 0);
    check("sw_c4_done", done, 0);

    // signed byte load with three wait cycles
    memready = 1'b0;
    memout   = 32'h12345680;
    issue(5'b10110, 5'd3, 22'h00010);
    check("lb_c1_memread", memread, 1);
    check("lb_c1_memaddress", memaddress, 22'h00010);
    tick();
    check("lb_c2_memread", memread, 1);
    tick();
    check("lb_c3_memread", memread, 1);
    tick();
    check("lb_c4_memread", memread, 1);
    memready = 1'b1;
    tick();
    check("lb_c5_regwrite", regwrite, 1);
    check("lb_c5_regdst", regdst, 3);
    check("lb_c5_regin", regin, 32'hFFFFFF80);
    check("lb_c5_memread", memread, 0);
    tick();
    check("lb_c6_done_err", {done, err}, 2'b10);
    tick();

    // load extension table
    for (int i = 0; i < 4; i++) begin
      memout = lmem[i];
      issue(lop[i], 5'd9, 22'h3FFFFF);
      check("ld_c1_memread", memread, 1);
      tick();
      check("ld_c2_regin", regin, lexp[i]);
      check("ld_c2_regdst", regdst, 9);
      tick();
      check("ld_c3_done", done, 1);
      tick();
    end

    // store half and byte
    regout1 = 32'hCAFE8001;
    issue(5'b11001, 5'd2, 22'h00100);
    tick();
    check("sh_memin", memin, 32'h00008001);
    check("sh_membe", membe, 4'b0011);
    tick();
    check("sh_done", done, 1);
    tick();
    issue(5'b11110, 5'd2, 22'h00101);
    tick();
    check("sb_memin", memin, 32'h00000001);
    check("sb_membe", membe, 4'b0001);
    tick();
    check("sb_done", done, 1);
    tick();

    // timeout
    memready  = 1'b0;
    mr_cycles = 0;
    saw_wr    = 1'b0;
    saw_done  = 1'b0;
    done_err  = 1'b0;
    issue(5'b10000, 5'd4, 22'h00200);
    for (int i = 0; i < 40 && !saw_done; i++) begin
      if (memread) mr_cycles++;
      if (regwrite) saw_wr = 1'b1;
      if (done) begin
        saw_done = 1'b1;
        done_err = err;
      end else begin
        tick();
      end
    end
    check("to_done_seen", saw_done, 1);
    check("to_memread_cycles", mr_cycles, 15);
    check("to_no_regwrite", saw_wr, 0);
    check("to_err", done_err, 1);
    tick();
    check("to_busy_after", busy, 0);

    // reset in the second MEMACC cycle
    issue(5'b10000, 5'd5, 22'h00300);
    tick();
    check("rst_c2_memread", memread, 1);
    reset = 1'b1;
    tick();
    check("rst_flags", flags, 0);
    check("rst_data", any_data, 0);
    reset    = 1'b0;
    memready = 1'b1;
    memout   = 32'h0BADF00D;
    issue(5'b10000, 5'd6, 22'h00301);
    check("post_c1_memread", memread, 1);
    tick();
    check("post_c2_regin", regin, 32'h0BADF00D);
    tick();
    check("post_c3_done_err", {done, err}, 2'b10);
    tick();

    // non-memory opcode is ignored
    issue(5'b00101, 5'd1, 22'h00001);
    check("nop_c1_flags", flags, 0);
    tick();
    check("nop_c2_flags", flags, 0);

    // re-pulsed enable while busy
    done_cnt = 0;
    opcode   = 5'b11000;
    rdst     = 5'd8;
    address  = 22'h00400;
    enable   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) enable = 1'b0;
      if (done) done_cnt++;
    end
    enable = 1'b0;
    check("repulse_done_count", done_cnt, 1);
    tick();

    // reserved sizes
    issue(5'b10011, 5'd1, 22'h00500);
    check("rsv_ld_done_err", {done, err}, 2'b11);
    check("rsv_ld_strobes", {regread, regwrite, memread, memwrite}, 0);
    tick();
    check("rsv_ld_busy_after", busy, 0);
    issue(5'b11111, 5'd1, 22'h00500);
    check("rsv_st_done_err", {done, err}, 2'b11);
    check("rsv_st_strobes", {regread, regwrite, memread, memwrite}, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loadstore_seq.md
# loadstore_seq

Parametrised, multi-cycle load/store unit sitting between instruction decode, the register file and data memory. It accepts one memory instruction per `enable` pulse. It reads the source register for stores and drives a memory access that holds until the memory acknowledges with `memready` or a timeout expires. It writes load data back with optional sub-word sign/zero extension, then reports completion with `done`/`err`.

## Interface
- `DATA_W`, 32: register/memory data width; multiple of 16, ≥16.
- `ADDR_W`, 22: memory address width.
- `REG_W`, 5: register index width.
- `TIMEOUT`, 15: maximum MEMACC cycles without `memready`; ≥1.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  start strobe; sampled only in IDLE.
- `opcode`  in  5  [4]=memory op, [3]=store(1)/load(0), [2]=sign-extend load, [1:0]=size (00 word, 01 half, 10 byte, 11 reserved).
- `rdst`  in  REG_W  data register (source for store, destination for load).
- `address`  in  ADDR_W  memory word address.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  high with `done` on timeout or reserved size.
- `regsrc1`  out  REG_W;  `regread`  out  1;  `regout1`  in  DATA_W (combinational register-file read data, valid same cycle).
- `regdst`  out  REG_W;  `regin`  out  DATA_W;  `regwrite`  out  1.
- `memaddress`  out  ADDR_W;  `memin`  out  DATA_W;  `membe`  out  DATA_W/8 byte enables;  `memread`  out  1;  `memwrite`  out  1.
- `memout`  in  DATA_W;  `memready`  in  1  access acknowledge; data valid in the same cycle for reads.

## Operation
- States: IDLE, RDREG, MEMACC, WB, FIN.
- IDLE: on `enable` with `opcode[4]=1`, latch `opcode`, `rdst`, `address`.
  - Size 11: go to FIN with err flagged.
  - Store: go to RDREG.
  - Load: go to MEMACC.
- IDLE with `enable` and `opcode[4]=0`: ignored. No state change, no `done`.
- RDREG: `regread=1`, `regsrc1=rdst`; latch `regout1`. Go to MEMACC.
- MEMACC: drive `memaddress` from the latched address and assert `memread` (load) or `memwrite` (store).
  - Store: `memin` = latched data with bits above the access size zeroed.
  - `membe`: word = all ones, half = 2'b11 in the low lanes, byte = 1'b1 in lane 0.
  - `memready=1`:
    - Load: latch the extended `memout`, go to WB.
    - Store: go to FIN.
  - `memready=0`: increment the wait counter. When the counter has reached `TIMEOUT-1`, go to FIN with err flagged. `memready` has priority over the timeout in the same cycle.
- Load extension: take the low 8/16/DATA_W bits of `memout`. `opcode[2]=1` replicates the top bit of the field; `opcode[2]=0` zero-fills. `opcode[2]` is ignored for word loads and for stores.
- WB: `regwrite=1`, `regdst=rdst`, `regin`=extended data. Go to FIN. `rdst=0` gets no special treatment.
- FIN: `done=1`, `err` = flagged condition. Go to IDLE and clear the flag and counter.
- Strobes are Moore outputs decoded from state. When not in their owning state, `regsrc1`, `regdst`, `regin`, `memaddress`, `memin` and `membe` drive 0.
- `enable` while `busy=1` is ignored; there is no queueing.

## Timing
- Reset:
  - State goes to IDLE; counter, err flag and data latch clear.
  - All outputs read 0 in the cycle after the reset edge, including `busy`, `done` and `err`.
- Reset mid-operation aborts immediately with no `done` and no further strobes. A write already asserted is not retracted.
- Latency is counted from the edge sampling `enable`, with `memready` high on the first MEMACC cycle:
  - Store: RDREG in cycle 1, MEMACC in cycle 2, `done` in cycle 3.
  - Load: MEMACC in cycle 1, WB in cycle 2, `done` in cycle 3.
- Each cycle of `memready=0` adds one cycle of latency.
- Timeout: `memread`/`memwrite` stay high for exactly `TIMEOUT` cycles, then `done`+`err` follow.
- Reserved size: `done`+`err` in cycle 1, with no register or memory strobe.
- A new `enable` is accepted in the cycle after FIN (IDLE). Minimum issue interval is 4 cycles.

## Test plan
- Store word: `opcode`=5'b11000, `rdst`=7, `address`=22'h00ABC, `regout1`=32'hDEADBEEF, `memready`=1.
  - Expect cycle 1 `regread`=1 with `regsrc1`=7.
  - Expect cycle 2 `memwrite`=1, `memaddress`=22'h00ABC, `memin`=32'hDEADBEEF, `membe`=4'b1111.
  - Expect cycle 3 `done`=1, `err`=0.
- Load byte signed: `opcode`=5'b10110, `rdst`=3, `memout`=32'h12345680, `memready` low for 3 MEMACC cycles.
  - Expect `memread` high in cycles 1–4.
  - Expect cycle 5 `regwrite`=1, `regdst`=3, `regin`=32'hFFFFFF80.
  - Expect `done` in cycle 6.
- Load half unsigned: `opcode`=5'b10001, `memout`=32'hCAFE8001 → `regin`=32'h00008001. Store half with `regout1`=32'hCAFE8001 → `memin`=32'h00008001, `membe`=4'b0011.
- Timeout, `TIMEOUT`=15: `memready` held 0 → `memread` high for exactly 15 cycles, no `regwrite`, then one cycle of `done`=`err`=1, then `busy`=0.
- Reset asserted in the second MEMACC cycle → the next cycle has all outputs 0 and no `done`. A following load completes normally in 3 cycles.
- Ignored requests:
  - `enable` with `opcode`=5'b00101 → no activity.
  - `enable` re-pulsed while busy → exactly one `done`.
  - `opcode[1:0]`=11 → `done`+`err` in cycle 1 with no strobes.
